// File: rtl/gonsolo_io_pkg.sv
// Shared types and constants for the gonsolo IO sequencer: FSM states, pattern modes,
// bounce direction, config register addresses and reset values.
package gonsolo_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    COUNT  = 2'd1,
    ROTATE = 2'd2,
    BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_PATTERN  = 2'd2;
  localparam logic [1:0] ADDR_OEMASK   = 2'd3;

  localparam logic [2:0] CTRL_RST     = 3'b000;
  localparam int         PATTERN_RST  = 1;
  localparam int         PRESCALE_RST = 0;
  localparam int         OEMASK_RST   = 0;

endpackage

// File: rtl/gonsolo_io_prescaler.sv
// Step prescaler: counts RUN cycles and emits a one-cycle step when the count
// reaches the programmed prescale value; a clear restarts the count without stepping.
module gonsolo_io_prescaler
  import gonsolo_io_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  run_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  step_o
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic                  hit;

  assign hit    = (count_q == prescale_i);
  assign step_o = run_i && !clear_i && hit;

  // Outside RUN the counter parks at zero, so every RUN entry starts a fresh interval.
  always_comb begin
    count_d = count_q + PRESCALE_W'(1);
    if (!run_i || clear_i || hit) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      count_q <= PRESCALE_W'(PRESCALE_RST);
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gonsolo_io_sequencer.sv
// IO pattern sequencer: a small config register file drives an IDLE/LOAD/RUN FSM that
// advances a pattern on the user IO slice by hold, count, rotate or bounce.
module gonsolo_io_sequencer
  import gonsolo_io_pkg::*;
#(
  parameter int N_IO       = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic [N_IO-1:0] io_out,
  output logic [N_IO-1:0] io_oeb,
  output logic            step,
  output logic            busy
);

  state_e                state_q;
  dir_e                  dir_q;
  dir_e                  dir_d;
  logic [N_IO-1:0]       ioOut_q;
  logic [N_IO-1:0]       ioOut_d;
  logic [2:0]            ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [N_IO-1:0]       pattern_q;
  logic [N_IO-1:0]       oemask_q;

  logic  cfgAccept;
  logic  wrCtrl;
  logic  wrPattern;
  logic  enable_d;
  logic  stepPulse;
  mode_e mode;

  assign cfg_ready = (state_q != LOAD);
  assign busy      = (state_q != IDLE);
  assign io_out    = ioOut_q;
  assign io_oeb    = ~oemask_q;
  assign step      = stepPulse;

  assign cfgAccept = cfg_valid && cfg_ready;
  assign wrCtrl    = cfgAccept && (cfg_addr == ADDR_CTRL);
  assign wrPattern = cfgAccept && (cfg_addr == ADDR_PATTERN);
  assign enable_d  = wrCtrl ? cfg_wdata[0] : ctrl_q[0];
  assign mode      = mode_e'(ctrl_q[2:1]);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ctrl_q     <= CTRL_RST;
      prescale_q <= PRESCALE_W'(PRESCALE_RST);
      pattern_q  <= N_IO'(PATTERN_RST);
      oemask_q   <= N_IO'(OEMASK_RST);
    end else if (cfgAccept) begin
      unique case (cfg_addr)
        ADDR_CTRL:     ctrl_q     <= cfg_wdata[2:0];
        ADDR_PRESCALE: prescale_q <= PRESCALE_W'(cfg_wdata);
        ADDR_PATTERN:  pattern_q  <= N_IO'(cfg_wdata);
        ADDR_OEMASK:   oemask_q   <= N_IO'(cfg_wdata);
        default:       ;
      endcase
    end
  end

  // Any write that can change timing or the pattern restarts the interval and eats the step.
  gonsolo_io_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clock     (clock),
    .resetb    (resetb),
    .run_i     (state_q == RUN),
    .clear_i   (cfgAccept && (cfg_addr != ADDR_OEMASK)),
    .prescale_i(prescale_q),
    .step_o    (stepPulse)
  );

  always_comb begin
    ioOut_d = ioOut_q;
    dir_d   = dir_q;
    unique case (mode)
      HOLD:   ioOut_d = ioOut_q;
      COUNT:  ioOut_d = ioOut_q + N_IO'(1);
      ROTATE: ioOut_d = {ioOut_q[N_IO-2:0], ioOut_q[N_IO-1]};
      BOUNCE: begin
        // Direction flips when the shifted pattern lands on the edge it was moving toward.
        if (dir_q == DIR_LEFT) begin
          ioOut_d = ioOut_q << 1;
          if (ioOut_d[N_IO-1]) dir_d = DIR_RIGHT;
        end else begin
          ioOut_d = ioOut_q >> 1;
          if (ioOut_d[0]) dir_d = DIR_LEFT;
        end
      end
      default: ioOut_d = ioOut_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      ioOut_q <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      unique case (state_q)
        IDLE: begin
          ioOut_q <= '0;
          if (enable_d) state_q <= LOAD;
        end
        LOAD: begin
          state_q <= RUN;
          ioOut_q <= pattern_q;
          dir_q   <= DIR_LEFT;
        end
        RUN: begin
          if (wrCtrl && !cfg_wdata[0]) begin
            state_q <= IDLE;
            ioOut_q <= '0;
          end else if (wrCtrl || wrPattern) begin
            state_q <= LOAD;
          end else if (stepPulse) begin
            ioOut_q <= ioOut_d;
            dir_q   <= dir_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gonsolo_io_sequencer.sv
// Directed self-checking bench for gonsolo_io_sequencer: count/wrap, rotate with
// prescale, bounce, write-vs-step collisions, output enables, async reset and disable.
module tb_gonsolo_io_sequencer;

   localparam int N_IO       = 8;
   localparam int PRESCALE_W = 16;

   logic            clock     = 1'b0;
   logic            resetb    = 1'b0;
   logic            cfgValid  = 1'b0;
   logic [1:0]      cfgAddr   = '0;
   logic [15:0]     cfgWdata  = '0;
   logic            cfgReady;
   logic [N_IO-1:0] ioOut;
   logic [N_IO-1:0] ioOeb;
   logic            step;
   logic            busy;

   int compared   = 0;
   int mismatched = 0;

   gonsolo_io_sequencer #(
      .N_IO(N_IO),
      .PRESCALE_W(PRESCALE_W)
   ) dut (
      .clock    (clock),
      .resetb   (resetb),
      .cfg_valid(cfgValid),
      .cfg_ready(cfgReady),
      .cfg_addr (cfgAddr),
      .cfg_wdata(cfgWdata),
      .io_out   (ioOut),
      .io_oeb   (ioOeb),
      .step     (step),
      .busy     (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Full register write: present at a falling edge, accepted on the next rising edge.
   task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
      @(negedge clock);
      cfgValid = 1'b1;
      cfgAddr  = addr;
      cfgWdata = data;
      @(posedge clock);
      #1 cfgValid = 1'b0;
   endtask

   // Present a write right now, so the caller can inspect outputs before the accepting edge.
   task automatic driveWrite(input logic [1:0] addr, input logic [15:0] data);
      cfgValid = 1'b1;
      cfgAddr  = addr;
      cfgWdata = data;
   endtask

   // Let the pending write be accepted, then withdraw it.
   task automatic endWrite();
      @(posedge clock);
      #1 cfgValid = 1'b0;
   endtask

   // Main directed sequence; expected values are hand-derived from the register and FSM rules.
   initial begin
      logic [7:0] rotExp [3];
      logic [7:0] bncExp [10];
      int         stepCount;

      rotExp = '{8'h81, 8'h03, 8'h06};
      bncExp = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

      repeat (2) @(negedge clock);
      checkOutput("rstIoOut", 32'(ioOut), 32'h00);
      checkOutput("rstIoOeb", 32'(ioOeb), 32'hFF);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstStep", 32'(step), 32'd0);
      resetb = 1'b1;
      @(negedge clock);
      checkOutput("idleReady", 32'(cfgReady), 32'd1);

      // Count mode with prescale 0: one increment per RUN cycle.
      applyStimulus(2'd2, 16'h0001);
      applyStimulus(2'd1, 16'h0000);
      applyStimulus(2'd0, 16'h0003);
      @(negedge clock);
      checkOutput("cntLoadReady", 32'(cfgReady), 32'd0);
      checkOutput("cntLoadBusy", 32'(busy), 32'd1);
      checkOutput("cntLoadStep", 32'(step), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput($sformatf("cntIoOut%0d", i), 32'(ioOut), 32'(i + 1));
         checkOutput($sformatf("cntStep%0d", i), 32'(step), 32'd1);
      end

      // Pattern write colliding with a step: write wins, LOAD follows, then wrap past all-ones.
      driveWrite(2'd2, 16'h00FF);
      #1 checkOutput("collideStep", 32'(step), 32'd0);
      endWrite();
      @(negedge clock);
      checkOutput("collideLoadReady", 32'(cfgReady), 32'd0);
      checkOutput("collideHeldIo", 32'(ioOut), 32'h03);
      @(negedge clock);
      checkOutput("wrapPre", 32'(ioOut), 32'hFF);
      checkOutput("wrapPreStep", 32'(step), 32'd1);
      @(negedge clock);
      checkOutput("wrapPost", 32'(ioOut), 32'h00);

      // Rotate with prescale 3: a step on every fourth RUN cycle.
      applyStimulus(2'd0, 16'h0000);
      @(negedge clock);
      checkOutput("stopBusy", 32'(busy), 32'd0);
      checkOutput("stopIoOut", 32'(ioOut), 32'h00);
      applyStimulus(2'd2, 16'h0081);
      applyStimulus(2'd1, 16'h0003);
      applyStimulus(2'd0, 16'h0005);
      @(negedge clock);
      checkOutput("rotLoadReady", 32'(cfgReady), 32'd0);
      @(negedge clock);
      checkOutput("rotRunReady", 32'(cfgReady), 32'd1);
      for (int k = 0; k < 12; k++) begin
         checkOutput($sformatf("rotIo%0d", k), 32'(ioOut), 32'(rotExp[k / 4]));
         checkOutput($sformatf("rotStep%0d", k), 32'(step), 32'((k % 4) == 3));
         @(negedge clock);
      end

      // Bounce from 0x40 with prescale 0.
      applyStimulus(2'd0, 16'h0000);
      applyStimulus(2'd2, 16'h0040);
      applyStimulus(2'd1, 16'h0000);
      applyStimulus(2'd0, 16'h0007);
      @(negedge clock);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         checkOutput($sformatf("bncIo%0d", k), 32'(ioOut), 32'(bncExp[k]));
      end

      // Prescale write in RUN restarts the interval and suppresses the pending step.
      driveWrite(2'd1, 16'h0002);
      #1 checkOutput("preWrStep", 32'(step), 32'd0);
      endWrite();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checkOutput($sformatf("preStep%0d", k), 32'(step), 32'(k == 2));
      end
      checkOutput("preHeldIo", 32'(ioOut), 32'h02);

      // Output enables track OEMASK; asynchronous reset aborts RUN immediately.
      applyStimulus(2'd3, 16'h000F);
      @(negedge clock);
      checkOutput("oebRun", 32'(ioOeb), 32'hF0);
      checkOutput("oebRunBusy", 32'(busy), 32'd1);
      #2 resetb = 1'b0;
      #1;
      checkOutput("asyncIoOut", 32'(ioOut), 32'h00);
      checkOutput("asyncIoOeb", 32'(ioOeb), 32'hFF);
      checkOutput("asyncBusy", 32'(busy), 32'd0);
      @(negedge clock);
      resetb = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("postRstBusy", 32'(busy), 32'd0);
      checkOutput("postRstStep", 32'(step), 32'd0);
      checkOutput("postRstReady", 32'(cfgReady), 32'd1);
      applyStimulus(2'd3, 16'h000F);
      @(negedge clock);
      checkOutput("oebIdle", 32'(ioOeb), 32'hF0);
      applyStimulus(2'd0, 16'h0003);
      @(negedge clock);
      checkOutput("oebLoad", 32'(ioOeb), 32'hF0);
      checkOutput("loadIoOut", 32'(ioOut), 32'h00);
      @(negedge clock);
      checkOutput("rstPattern", 32'(ioOut), 32'h01);
      checkOutput("rstPatternStep", 32'(step), 32'd1);
      checkOutput("oebRun2", 32'(ioOeb), 32'hF0);

      // Disable during RUN: IDLE next cycle, pattern cleared, no further steps.
      driveWrite(2'd0, 16'h0000);
      #1 checkOutput("disStep", 32'(step), 32'd0);
      endWrite();
      @(negedge clock);
      checkOutput("disBusy", 32'(busy), 32'd0);
      checkOutput("disIoOut", 32'(ioOut), 32'h00);
      stepCount = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clock);
         if (step) stepCount++;
      end
      checkOutput("disNoSteps", 32'(stepCount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gonsolo_io_sequencer.md
GONSOLO_IO_SEQUENCER -- requirements
Module: gonsolo_io_sequencer

Interface
REQ-001 Parameter N_IO, default 8, width of driven user IO slice (mprj_io[N_IO-1:0]).
REQ-002 Parameter PRESCALE_W, default 16, width of step prescaler.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 resetb  in  1  reset, asynchronous assert, active-low.
REQ-005 cfg_valid  in  1  config write request.
REQ-006 cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready.
REQ-007 cfg_addr  in  2  register select: 0 CTRL, 1 PRESCALE, 2 PATTERN, 3 OEMASK.
REQ-008 cfg_wdata  in  16  write data; upper bits beyond register width ignored.
REQ-009 io_out  out  N_IO  pattern driven to user IO.
REQ-010 io_oeb  out  N_IO  output-enable-bar per IO; io_oeb = ~OEMASK.
REQ-011 step  out  1  one-cycle pulse on each pattern advance.
REQ-012 busy  out  1  high in LOAD or RUN.

Function
REQ-013 Registers: CTRL[0]=enable, CTRL[2:1]=mode; PRESCALE[PRESCALE_W-1:0]; PATTERN[N_IO-1:0]; OEMASK[N_IO-1:0]; write updates register on handshake edge.
REQ-014 FSM states IDLE, LOAD, RUN; IDLE->LOAD when enable=1; LOAD->RUN unconditionally after one cycle; RUN->IDLE the cycle after enable written 0; RUN->LOAD on accepted write to PATTERN or CTRL with enable=1.
REQ-015 cfg_ready = 0 in LOAD, 1 otherwise.
REQ-016 LOAD: io_out <= PATTERN, prescale counter <= 0, bounce direction <= left.
REQ-017 RUN: counter increments each cycle; when counter == PRESCALE, step=1 for that cycle, counter <= 0; PRESCALE=0 gives step every RUN cycle.
REQ-018 Accepted PRESCALE write in RUN resets counter to 0 that edge, no step that cycle.
REQ-019 On step, mode 0 hold; mode 1 io_out <= io_out+1 modulo 2^N_IO (all-ones wraps to 0); mode 2 rotate left by 1 (MSB to bit 0); mode 3 bounce.
REQ-020 Bounce: shift left while direction=left; if bit N_IO-1 set after shift, direction<=right; shift right while right; if bit 0 set after shift, direction<=left; zero pattern stays zero.
REQ-021 Write to PATTERN/CTRL coinciding with step: write wins, step suppressed (step=0), FSM goes to LOAD.
REQ-022 Entry to IDLE clears io_out to 0 and counter to 0; io_oeb follows OEMASK in all states.
REQ-023 busy = (state != IDLE), combinational from state.

Reset
REQ-024 resetb low asynchronously forces: state IDLE, io_out 0, step 0, CTRL 0, PRESCALE 0, PATTERN 1, OEMASK 0 (io_oeb all ones), counter 0, direction left.
REQ-025 Reset mid-RUN aborts immediately; first step after release requires fresh enable write plus LOAD.
REQ-026 cfg_ready is 1 while held in reset-released IDLE; no writes accepted while resetb low.

Structure
REQ-027 Package gonsolo_io_pkg holds state enum (IDLE/LOAD/RUN), mode enum (HOLD/COUNT/ROTATE/BOUNCE), register address constants, reset values.
REQ-028 Sub-module gonsolo_io_prescaler: counter, compare, clear, step output; FSM, registers, pattern update in top.

Verification
REQ-029 Reset, write PATTERN=0x01, PRESCALE=0, CTRL=0b011 (count) -> LOAD then io_out 0x01,0x02,0x03 on consecutive cycles, step high each RUN cycle; 0xFF -> 0x00 wrap.
REQ-030 PRESCALE=3, mode rotate, PATTERN=0x81 -> step every 4th cycle; io_out 0x81,0x03,0x06; cfg_ready low exactly one cycle after enable write.
REQ-031 Bounce, PATTERN=0x40, PRESCALE=0 -> 0x40,0x80,0x40,0x20 ... 0x01,0x02.
REQ-032 PATTERN write on same cycle as step -> step=0 that cycle, next cycle LOAD, io_out=new pattern.
REQ-033 OEMASK=0x0F -> io_oeb=0xF0 in every state; resetb low mid-RUN -> io_out 0x00, io_oeb 0xFF, busy 0 asynchronously.
REQ-034 CTRL=0 during RUN -> next cycle IDLE, io_out 0x00, no further step pulses over 1000 cycles.
